// File: rtl/fetch_if.sv
// Flash-read and decode-handoff signals of the fetch sequencer.
// master: fetch_sequencer side; slave: flash/decode side.
interface fetch_if #(
  parameter int ADDR_WIDTH  = 12,
  parameter int INSTR_WIDTH = 16
);
  logic                   flash_req;
  logic [ADDR_WIDTH-1:0]  flash_addr;
  logic                   flash_ready;
  logic [INSTR_WIDTH-1:0] flash_rdata;
  logic                   instr_valid;
  logic [INSTR_WIDTH-1:0] instr_data;
  logic [ADDR_WIDTH-1:0]  instr_pc;
  logic                   instr_ready;

  modport master (
    output flash_req, flash_addr, instr_valid, instr_data, instr_pc,
    input  flash_ready, flash_rdata, instr_ready
  );

  modport slave (
    input  flash_req, flash_addr, instr_valid, instr_data, instr_pc,
    output flash_ready, flash_rdata, instr_ready
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: PC strobes, flash reads, decode handoff, redirect/halt.
// Optional flash timeout enabled with macro FETCH_TIMEOUT_EN.
module fetch_sequencer #(
  parameter int ADDR_WIDTH  = 12,
  parameter int INSTR_WIDTH = 16
`ifdef FETCH_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 255
`endif
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic [ADDR_WIDTH-1:0] pc_out,
  output logic                  pc_inc,
  output logic                  pc_load,
  output logic [ADDR_WIDTH-1:0] pc_next,
  fetch_if.master               bus,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_addr,
  input  logic                  halt,
  output logic                  fetch_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    HOLD   = 2'd2,
    HALTED = 2'd3
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  state_t                 state_r, state_n_s;
  logic [ADDR_WIDTH-1:0]  req_addr_r, pend_addr_r, instr_pc_r;
  logic [INSTR_WIDTH-1:0] instr_data_r;
  logic                   from_redir_r, pending_r, stale_r;
  logic                   flash_req_r, instr_valid_r, fetch_err_r;
  logic                   enter_req_s, capture_s, timeout_hit_s;

`ifdef FETCH_TIMEOUT_EN
  localparam int TMR_W = ($clog2(TIMEOUT_CYCLES + 1) < 8) ? 8 : $clog2(TIMEOUT_CYCLES + 1);
  logic [TMR_W-1:0] timer_r;

  assign timeout_hit_s = (timer_r == TMR_W'(TIMEOUT_CYCLES - 1));

  // REQ-cycle counter, restarted whenever a new request is issued
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      timer_r <= '0;
    end else if (enter_req_s) begin
      timer_r <= '0;
    end else if (state_r == REQ) begin
      timer_r <= timer_r + TMR_W'(1);
    end else begin
      timer_r <= timer_r;
    end
  end
`else
  assign timeout_hit_s = 1'b0;
`endif

  // Next-state decode and combinational PC strobes
  always_comb begin
    state_n_s   = state_r;
    enter_req_s = 1'b0;
    capture_s   = 1'b0;
    pc_inc      = 1'b0;
    pc_load     = 1'b0;
    pc_next     = '0;
    case (state_r)
      IDLE: begin
        state_n_s   = REQ;
        enter_req_s = 1'b1;
      end
      REQ: begin
        if (bus.flash_ready) begin
          if (redirect_valid || stale_r) begin
            state_n_s   = REQ;
            enter_req_s = 1'b1;
          end else begin
            state_n_s = HOLD;
            capture_s = 1'b1;
            if (from_redir_r) begin
              pc_load = 1'b1;
              pc_next = req_addr_r + ADDR_ONE;
            end else begin
              pc_inc = 1'b1;
            end
          end
        end else if (timeout_hit_s) begin
          state_n_s = HALTED;
        end else begin
          state_n_s = REQ;
        end
      end
      HOLD: begin
        if (bus.instr_ready) begin
          if (halt) begin
            state_n_s = HALTED;
          end else begin
            state_n_s   = REQ;
            enter_req_s = 1'b1;
          end
        end else if (redirect_valid) begin
          state_n_s   = REQ;
          enter_req_s = 1'b1;
        end else begin
          state_n_s = HOLD;
        end
      end
      HALTED: begin
        if (!halt && !fetch_err_r) begin
          state_n_s   = REQ;
          enter_req_s = 1'b1;
        end else begin
          state_n_s = HALTED;
        end
      end
      default: begin
        state_n_s = IDLE;
      end
    endcase
  end

  // State, request address, redirect bookkeeping and instruction capture
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      state_r       <= IDLE;
      req_addr_r    <= '0;
      pend_addr_r   <= '0;
      from_redir_r  <= 1'b0;
      pending_r     <= 1'b0;
      stale_r       <= 1'b0;
      flash_req_r   <= 1'b0;
      instr_valid_r <= 1'b0;
      instr_data_r  <= '0;
      instr_pc_r    <= '0;
      fetch_err_r   <= 1'b0;
    end else begin
      state_r       <= state_n_s;
      flash_req_r   <= (state_n_s == REQ);
      instr_valid_r <= (state_n_s == HOLD);
      // A redirect arriving on the entry cycle itself takes priority (latest wins)
      if (enter_req_s) begin
        if (redirect_valid) begin
          req_addr_r   <= redirect_addr;
          from_redir_r <= 1'b1;
        end else if (pending_r) begin
          req_addr_r   <= pend_addr_r;
          from_redir_r <= 1'b1;
        end else begin
          req_addr_r   <= pc_out;
          from_redir_r <= 1'b0;
        end
        pending_r <= 1'b0;
      end else if (redirect_valid) begin
        pending_r <= 1'b1;
      end else begin
        pending_r <= pending_r;
      end
      if (redirect_valid) begin
        pend_addr_r <= redirect_addr;
      end
      if (enter_req_s || (state_r == REQ && bus.flash_ready)) begin
        stale_r <= 1'b0;
      end else if (state_r == REQ && redirect_valid) begin
        stale_r <= 1'b1;
      end else begin
        stale_r <= stale_r;
      end
      if (capture_s) begin
        instr_data_r <= bus.flash_rdata;
        instr_pc_r   <= req_addr_r;
      end
      if (state_r == REQ && !bus.flash_ready && timeout_hit_s) begin
        fetch_err_r <= 1'b1;
      end
    end
  end

  assign bus.flash_req   = flash_req_r;
  assign bus.flash_addr  = req_addr_r;
  assign bus.instr_valid = instr_valid_r;
  assign bus.instr_data  = instr_data_r;
  assign bus.instr_pc    = instr_pc_r;
  assign fetch_err       = fetch_err_r;

endmodule
